// File: rtl/addsub_serial.sv
// addsub_serial: slice-serial add/subtract with valid/ready handshake and registered S/Z/C/O/N
module addsub_serial #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Z,
  output logic             C,
  output logic             O,
  output logic             N
);
  localparam int NSL = WIDTH / SLICE;
  localparam int KW = NSL > 1 ? $clog2(NSL) : 1;
  if (SLICE < 1 || SLICE > WIDTH || WIDTH % SLICE != 0) begin : g_bad_cfg
    $error("addsub_serial: WIDTH must be a positive multiple of SLICE");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] op_a, op_w, acc, res;
  logic [KW-1:0] k;
  logic carry, last;
  logic [SLICE:0] sl;
  assign last = k == KW'(NSL - 1);
  assign sl = {1'b0, op_a[k*SLICE +: SLICE]} + {1'b0, op_w[k*SLICE +: SLICE]} + {{SLICE{1'b0}}, carry};
  always_comb begin
    res = acc;
    res[k*SLICE +: SLICE] = sl[SLICE-1:0];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE ? (in_valid ? RUN : IDLE) :
          state == RUN  ? (last ? DONE : RUN) :
                          (out_ready ? IDLE : DONE);
  always_comb begin
    in_ready = (state == IDLE) & ~rst;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op_a <= '0;
      op_w <= '0;
      acc <= '0;
      k <= '0;
      carry <= 1'b0;
      S <= '0;
      Z <= 1'b0;
      C <= 1'b0;
      O <= 1'b0;
      N <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      op_a <= A;
      op_w <= B ^ {WIDTH{Cin}};
      carry <= Cin;
      k <= '0;
    end else if (state == RUN) begin
      acc <= res;
      carry <= sl[SLICE];
      k <= k + KW'(1);
      if (last) begin
        S <= res;
        C <= sl[SLICE];
        Z <= res == '0;
        N <= res[WIDTH-1];
        O <= (op_a[WIDTH-1] == op_w[WIDTH-1]) & (res[WIDTH-1] != op_a[WIDTH-1]);
      end
    end
endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: directed checks of addsub_serial in default and single-slice configurations
module tb_addsub_serial;
  logic clk = 0, rst = 0, in_valid = 0, out_ready = 0, Cin = 0;
  logic [15:0] A = 0, B = 0;
  logic in_ready, out_valid, Z, C, O, N;
  logic [15:0] S;
  logic in_valid8 = 0, out_ready8 = 0, cin8 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic in_ready8, out_valid8, z8, c8, o8, n8;
  logic [7:0] s8;
  int checks = 0, failures = 0, lat = 0;
  addsub_serial #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B), .Cin(Cin),
    .out_valid(out_valid), .out_ready(out_ready), .S(S), .Z(Z), .C(C), .O(O), .N(N));
  addsub_serial #(.WIDTH(8), .SLICE(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .A(a8), .B(b8), .Cin(cin8),
    .out_valid(out_valid8), .out_ready(out_ready8), .S(s8), .Z(z8), .C(c8), .O(o8), .N(n8));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic op(input logic [15:0] a, input logic [15:0] b, input logic cin, output int l);
    @(negedge clk);
    A = a;
    B = b;
    Cin = cin;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    l = 0;
    while (!out_valid && l < 20) begin
      @(posedge clk);
      #1 l++;
    end
  endtask
  task automatic consume;
    @(negedge clk);
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    chk("consume_out_valid", out_valid, 0);
    chk("consume_in_ready", in_ready, 1);
  endtask
  initial begin
    #3 rst = 1;
    #4;
    chk("rst_s", S, 16'h0000);
    chk("rst_flags", {Z, C, O, N}, 4'b0000);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst8_s", s8, 8'h00);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 0;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    op(16'h7FFF, 16'h0001, 0, lat);
    chk("ovf_latency", lat, 4);
    chk("ovf_s", S, 16'h8000);
    chk("ovf_zcon", {Z, C, O, N}, 4'b0011);
    consume();
    op(16'h1234, 16'h1234, 1, lat);
    chk("sub_eq_s", S, 16'h0000);
    chk("sub_eq_zcon", {Z, C, O, N}, 4'b1100);
    consume();
    op(16'h0000, 16'h0001, 1, lat);
    chk("sub_neg_s", S, 16'hFFFF);
    chk("sub_neg_zcon", {Z, C, O, N}, 4'b0001);
    consume();
    op(16'h8000, 16'h0001, 1, lat);
    chk("sub_ovf_s", S, 16'h7FFF);
    chk("sub_ovf_zcon", {Z, C, O, N}, 4'b0110);
    consume();
    chk("hold_idle_s", S, 16'h7FFF);
    op(16'h0100, 16'h0020, 0, lat);
    chk("bp_s", S, 16'h0120);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      A = 16'hFFFF;
      B = 16'hFFFF;
      Cin = i[0];
      in_valid = ~in_valid;
      chk("bp_hold_s", S, 16'h0120);
      chk("bp_hold_flags", {Z, C, O, N}, 4'b0000);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    in_valid = 0;
    consume();
    op(16'h0005, 16'h0006, 0, lat);
    chk("fresh_latency", lat, 4);
    chk("fresh_s", S, 16'h000B);
    chk("fresh_flags", {Z, C, O, N}, 4'b0000);
    consume();
    @(negedge clk);
    A = 16'hFFFF;
    B = 16'h0001;
    Cin = 0;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("midrst_s", S, 16'h0000);
    chk("midrst_flags", {Z, C, O, N}, 4'b0000);
    chk("midrst_in_ready", in_ready, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) rst = 0;
      chk("midrst_no_valid", out_valid, 0);
      chk("midrst_s_zero", S, 16'h0000);
    end
    op(16'h0003, 16'h0004, 0, lat);
    chk("post_rst_latency", lat, 4);
    chk("post_rst_s", S, 16'h0007);
    chk("post_rst_flags", {Z, C, O, N}, 4'b0000);
    consume();
    @(negedge clk);
    a8 = 8'hFF;
    b8 = 8'h01;
    cin8 = 0;
    in_valid8 = 1;
    @(posedge clk);
    #1 in_valid8 = 0;
    lat = 0;
    while (!out_valid8 && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("w8_latency", lat, 1);
    chk("w8_s", s8, 8'h00);
    chk("w8_zcon", {z8, c8, o8, n8}, 4'b1100);
    @(negedge clk);
    out_ready8 = 1;
    @(posedge clk);
    #1 out_ready8 = 0;
    chk("w8_consume", out_valid8, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
